// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M/RV64M multiply/divide unit: funct3 encodings,
// FSM states and the operand-signedness decode.
package muldiv_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   // second=0 asks about rs1, second=1 about rs2 (MULHSU is signed on rs1 only)
   function automatic logic is_signed_op(input logic [2:0] f3, input logic second);
      logic s;
      case (f3)
         F3_MULH, F3_DIV, F3_REM: s = 1'b1;
         F3_MULHSU:               s = ~second;
         default:                 s = 1'b0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/rv_muldiv_unit_if.sv
// Issue/completion bundle between the EXEC stage (master) and the mul/div unit (slave).
interface rv_muldiv_unit_if #(parameter int XLEN = 32);

   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;
   logic [4:0]      rd_in;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;

   modport master (
      output start, funct3, src1, src2, rd_in, flush,
      input  busy, done, result, rd_out
   );

   modport slave (
      input  start, funct3, src1, src2, rd_in, flush,
      output busy, done, result, rd_out
   );

endinterface

// File: rtl/rv_div_step.sv
// One restoring-division step on unsigned magnitudes: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, keep or restore.
module rv_div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_rem,
   input  logic [XLEN-1:0] i_quo,
   input  logic [XLEN-1:0] i_div,
   output logic [XLEN-1:0] o_rem,
   output logic [XLEN-1:0] o_quo
);

   logic [XLEN:0] w_shift;
   logic [XLEN:0] w_diff;

   assign w_shift = {i_rem, i_quo[XLEN-1]};
   assign w_diff  = w_shift - {1'b0, i_div};

   // A clear borrow bit means the divisor fits: keep the difference, emit a 1
   always_comb begin
      if (w_diff[XLEN] == 1'b0) begin
         o_rem = w_diff[XLEN-1:0];
         o_quo = {i_quo[XLEN-2:0], 1'b1};
      end else begin
         o_rem = w_shift[XLEN-1:0];
         o_quo = {i_quo[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative RV M-extension unit: shift-add multiply and restoring divide on operand
// magnitudes, UNROLL bits per cycle, with sign fix-up folded into the last iteration.
module rv_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic            clk,
   input  logic            reset,
   rv_muldiv_unit_if.slave bus
);

   localparam int K  = XLEN / UNROLL;
   localparam int CW = $clog2(K + 1);
   localparam logic [CW-1:0]   LAST    = CW'(K - 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};

   state_t            r_state;
   logic [2:0]        r_f3;
   logic [4:0]        r_rd;
   logic [XLEN-1:0]   r_b;
   logic              r_neg_q;
   logic              r_neg_r;
   logic [CW-1:0]     r_cnt;
   logic [2*XLEN-1:0] r_prod;
   logic [XLEN-1:0]   r_quo;
   logic [XLEN-1:0]   r_rem;
   logic              r_busy;
   logic              r_done;
   logic [XLEN-1:0]   r_result;
   logic [4:0]        r_rd_out;

   logic              w_accept;
   logic              w_neg1;
   logic              w_neg2;
   logic [XLEN-1:0]   w_abs1;
   logic [XLEN-1:0]   w_abs2;
   logic              w_div0;
   logic              w_ovf;
   logic [XLEN-1:0]   w_fast_res;
   logic [XLEN:0]     w_sum;
   logic [2*XLEN-1:0] w_prod_nx;
   logic [2*XLEN-1:0] w_prod_fix;
   logic [XLEN-1:0]   w_quo_nx;
   logic [XLEN-1:0]   w_rem_nx;
   logic [XLEN-1:0]   w_quo_fix;
   logic [XLEN-1:0]   w_rem_fix;
   logic [XLEN-1:0]   w_final;
   logic [XLEN-1:0]   w_rem_ch [UNROLL+1];
   logic [XLEN-1:0]   w_quo_ch [UNROLL+1];

   assign w_accept = bus.start & ~r_busy & ~bus.flush;
   assign w_neg1   = is_signed_op(bus.funct3, 1'b0) & bus.src1[XLEN-1];
   assign w_neg2   = is_signed_op(bus.funct3, 1'b1) & bus.src2[XLEN-1];
   assign w_abs1   = w_neg1 ? -bus.src1 : bus.src1;
   assign w_abs2   = w_neg2 ? -bus.src2 : bus.src2;
   assign w_div0   = bus.funct3[2] & (bus.src2 == ZERO);
   assign w_ovf    = bus.funct3[2] & ~bus.funct3[0] & (bus.src1 == MIN_NEG) & (bus.src2 == ONES);

   // Divide-by-zero and signed overflow resolve at accept without iterating
   always_comb begin
      w_fast_res = ZERO;
      if (w_div0) begin
         w_fast_res = bus.funct3[1] ? bus.src1 : ONES;
      end else if (w_ovf) begin
         w_fast_res = bus.funct3[1] ? ZERO : bus.src1;
      end else begin
         w_fast_res = ZERO;
      end
   end

   // Multiply: {hi,lo} holds accumulator and remaining multiplier bits
   always_comb begin
      w_sum     = {(XLEN+1){1'b0}};
      w_prod_nx = r_prod;
      for (int i = 0; i < UNROLL; i++) begin
         w_sum     = {1'b0, w_prod_nx[2*XLEN-1:XLEN]}
                   + (w_prod_nx[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
         w_prod_nx = {w_sum, w_prod_nx[XLEN-1:1]};
      end
   end

   assign w_rem_ch[0] = r_rem;
   assign w_quo_ch[0] = r_quo;

   for (genvar g = 0; g < UNROLL; g++) begin : g_div
      rv_div_step #(.XLEN(XLEN)) u_step (
         .i_rem (w_rem_ch[g]),
         .i_quo (w_quo_ch[g]),
         .i_div (r_b),
         .o_rem (w_rem_ch[g+1]),
         .o_quo (w_quo_ch[g+1])
      );
   end

   assign w_quo_nx   = w_quo_ch[UNROLL];
   assign w_rem_nx   = w_rem_ch[UNROLL];
   assign w_prod_fix = r_neg_q ? -w_prod_nx : w_prod_nx;
   assign w_quo_fix  = r_neg_q ? -w_quo_nx  : w_quo_nx;
   assign w_rem_fix  = r_neg_r ? -w_rem_nx  : w_rem_nx;

   // Pick the architectural result for the latched op
   always_comb begin
      case (r_f3)
         F3_MUL:                       w_final = w_prod_fix[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              w_final = w_quo_fix;
         default:                      w_final = w_rem_fix;
      endcase
   end

   // FSM, datapath registers and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_f3     <= 3'b000;
         r_rd     <= 5'd0;
         r_b      <= ZERO;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_cnt    <= {CW{1'b0}};
         r_prod   <= {(2*XLEN){1'b0}};
         r_quo    <= ZERO;
         r_rem    <= ZERO;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= ZERO;
         r_rd_out <= 5'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            RUN: begin
               if (bus.flush) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_prod <= w_prod_nx;
                  r_quo  <= w_quo_nx;
                  r_rem  <= w_rem_nx;
                  r_cnt  <= r_cnt + CW'(1);
                  if (r_cnt == LAST) begin
                     r_state  <= FIN;
                     r_busy   <= 1'b0;
                     r_done   <= 1'b1;
                     r_result <= w_final;
                     r_rd_out <= r_rd;
                  end
               end
            end
            IDLE, FIN: begin
               if (w_accept) begin
                  r_f3    <= bus.funct3;
                  r_rd    <= bus.rd_in;
                  r_b     <= w_abs2;
                  r_neg_q <= w_neg1 ^ w_neg2;
                  r_neg_r <= w_neg1;
                  r_cnt   <= {CW{1'b0}};
                  r_prod  <= {ZERO, w_abs1};
                  r_quo   <= w_abs1;
                  r_rem   <= ZERO;
                  if (w_div0 | w_ovf) begin
                     r_state  <= FIN;
                     r_done   <= 1'b1;
                     r_result <= w_fast_res;
                     r_rd_out <= bus.rd_in;
                  end else begin
                     r_state <= RUN;
                     r_busy  <= 1'b1;
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.result = r_result;
   assign bus.rd_out = r_rd_out;

endmodule
